// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter state encoding and
// frame-timing helpers used by the TX block (and later the RX block).
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5,
    ST_MARK   = 3'd6
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of
// each period with bit_end. restart holds the count at zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign bit_end = (cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst || restart || bit_end) cnt <= '0;
    else                           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx_frame.sv
// Ready/valid UART transmitter: start bit, DATA_BITS data (LSB first), optional
// parity, STOP_BITS stop bits. Define UART_TX_BREAK_EN to add line-break sending.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef UART_TX_BREAK_EN
  input  logic                 send_break,
`endif
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int   CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int   IDX_W        = $clog2(DATA_BITS);
  localparam logic HAS_PARITY   = (PARITY != PAR_NONE);

  generate
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_frame: CLK_FREQ/BAUD_RATE must be >= 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_frame: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_par
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
  endgenerate

  tx_state_t            state;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_q;
  logic                 bit_end;
  logic                 restart;
  logic                 hs;
  logic                 brk_exit;

`ifdef UART_TX_BREAK_EN
  // Break refuses words so that a simultaneous s_valid never handshakes.
  assign s_ready = (state == ST_IDLE) && !rst && !send_break;
`else
  assign s_ready = (state == ST_IDLE) && !rst;
`endif

  assign hs      = s_valid && s_ready;
  assign busy    = (state != ST_IDLE);
  assign restart = (state == ST_IDLE) || brk_exit;

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .bit_end(bit_end)
  );

`ifdef UART_TX_BREAK_EN
  localparam int FRAME_CLKS = frame_bits(DATA_BITS, PARITY, STOP_BITS) * CLKS_PER_BIT;
  localparam int BRK_W      = $clog2(FRAME_CLKS);

  logic [BRK_W-1:0] brk_cnt;
  logic             brk_done;

  // Saturating count of break cycles; the line stays low for at least one frame.
  assign brk_done = (brk_cnt == BRK_W'(FRAME_CLKS - 1));
  assign brk_exit = (state == ST_BREAK) && brk_done && !send_break;

  always_ff @(posedge clk) begin
    if (rst || state != ST_BREAK) brk_cnt <= '0;
    else if (!brk_done)           brk_cnt <= brk_cnt + 1'b1;
  end
`else
  assign brk_exit = 1'b0;
`endif

  // Word capture at handshake; shifted out LSB first during DATA.
  always_ff @(posedge clk) begin
    if (hs) begin
      data_q <= s_data;
      par_q  <= (PARITY == PAR_ODD) ? ~^s_data : ^s_data;
    end else if (state == ST_DATA && bit_end) begin
      data_q <= {1'b0, data_q[DATA_BITS-1:1]};
    end
  end

  // Frame sequencer: tx is loaded with the value of the bit being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      tx      <= 1'b1;
      done    <= 1'b0;
      bit_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          bit_idx <= '0;
          tx      <= 1'b1;
          if (hs) begin
            state <= ST_START;
            tx    <= 1'b0;
          end
`ifdef UART_TX_BREAK_EN
          if (send_break) begin
            state <= ST_BREAK;
            tx    <= 1'b0;
          end
`endif
        end
        ST_START: begin
          if (bit_end) begin
            state <= ST_DATA;
            tx    <= data_q[0];
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (HAS_PARITY) begin
                state <= ST_PARITY;
                tx    <= par_q;
              end else begin
                state <= ST_STOP;
                tx    <= 1'b1;
              end
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= data_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
              state   <= ST_IDLE;
              done    <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        ST_BREAK: begin
          if (brk_exit) begin
            state <= ST_MARK;
            tx    <= 1'b1;
          end
        end
        ST_MARK: begin
          if (bit_end) state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter. Serialises one data word per ready/valid handshake into a standard async frame: start bit, configurable data bits, optional parity bit, then 1 or 2 stop bits. Runs entirely on clk; the bit period comes from a clock-enable counter, with no derived clock. It is the drop-in serial TX for all UART channels in the design.

Parameters:
CLK_FREQ, 1000000, system clock frequency in Hz.
BAUD_RATE, 9600, line rate in bit/s. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (truncated). Must be >= 2; elaboration error otherwise.
DATA_BITS, 8, data width, legal range 5..9.
PARITY, 0, parity mode: 0 none, 1 even, 2 odd.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  in  1  system clock.
rst  in  1  reset, synchronous, active-high.
s_valid  in  1  data word offered.
s_ready  out  1  block can accept a word.
s_data  in  DATA_BITS  word to send, LSB first.
tx  out  1  serial line, idle high.
busy  out  1  frame in progress.
done  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset values: tx=1, busy=0, done=0, state=IDLE. s_ready=0 while rst is high.
- Reset mid-frame aborts the frame: tx=1 on the next cycle, no done pulse.
- s_ready = (state==IDLE) && !rst. This is combinational from state.
- Handshake occurs on a cycle with s_valid && s_ready.
  - s_data is latched and parity computed on that cycle.
  - Later changes on s_data have no effect.
- States and transitions: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- A bit counter counts 0..CLKS_PER_BIT-1 and is restarted at every state entry. Each line bit is held exactly CLKS_PER_BIT cycles.
- tx is registered. The start bit (tx=0) appears on the cycle after the handshake.
- DATA state: sends s_data[0]..s_data[DATA_BITS-1]. An index counter advances on each bit-period wrap.
- PARITY state exists only if PARITY!=0.
  - Even: tx = ^data.
  - Odd: tx = ~^data.
- STOP state: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
- On the last STOP cycle: state<=IDLE and done<=1.
  - done is high for exactly the first IDLE cycle.
  - s_ready is also high in that cycle.
- Frame length = (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles.
- Back-to-back frames with s_valid held high: handshake-to-handshake period = frame length + 1 cycle. There is no other idle gap.
- busy = (state!=IDLE).

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - Adds input port send_break (1 bit) and a BREAK state.
  - When send_break is high in IDLE, go to BREAK. If send_break and s_valid are both high, break wins and no handshake occurs.
  - In BREAK: tx=0 and s_ready=0. Remain until send_break is low AND at least one frame length has elapsed.
  - Then drive tx=1 for one CLKS_PER_BIT mark period and return to IDLE. No done pulse.
- Undefined: the port and the BREAK state are absent; behaviour is exactly as above.

Decomposition:
- Package uart_pkg holds:
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2;
  - the tx state enum;
  - function clks_per_bit(clk_freq, baud);
  - function frame_bits(data_bits, parity, stop_bits).
- Sub-module uart_baud_gen: bit-period counter with restart input and a one-cycle bit_end tick. It is reusable by the future RX block.

Test Plan:
All cases use CLK_FREQ=1000000 and BAUD_RATE=100000, so CLKS_PER_BIT=10.
1. 8N1, send 0xA5.
   - tx bits = 0,1,0,1,0,0,1,0,1,1, each exactly 10 cycles.
   - done pulses 101 cycles after the handshake cycle; s_ready is high in the same cycle.
2. 8E1 and 8O1, send 0x07.
   - Parity bit is 1 for even and 0 for odd.
   - Frame is 110 cycles.
3. DATA_BITS=7, STOP_BITS=2, PARITY=0, send 0x55.
   - Bits: 0,1,0,1,0,1,0,1,1,1.
   - Stop high for 20 cycles; frame is 100 cycles.
4. 8N1, s_valid held with 0x00 then 0xFF.
   - Second start bit falls 101 cycles after the first start bit.
   - Handshake count = 2.
5. 8N1, send 0xFF, assert rst for 1 cycle at cycle 35 after the handshake.
   - tx=1 and busy=0 on the next cycle; no done.
   - Next word 0x3C transmits a complete, correct frame.
6. (UART_TX_BREAK_EN) send_break high for 200 cycles in IDLE.
   - tx=0 for 200 cycles, then tx=1 for 10 cycles, then s_ready=1.
   - With a 30-cycle pulse, tx stays low for 100 cycles.
